// File: rtl/phase_sequencer.sv
// phase_sequencer
//   Non-overlapping multi-phase clock generator. NPHASE one-hot phases
//   rotate in a fixed order. Each phase is held for ON_CYCLES clocks and
//   is followed by GAP_CYCLES all-low clocks. The sequencer can run freely,
//   halt at the end of a computer cycle, single-step one cycle at a time,
//   or stop at the next phase boundary when BOP (power-on) falls.
//
//   Every output is registered from the current sequencer state, so a start
//   condition sampled at edge n first shows up on the outputs after edge n+1.
//
// Ports
//   CLK, RST      clock and synchronous active-high reset
//   BOP           power-on/enable; low stops at the next phase boundary
//   HALT_REQ      request a halt at the end of the computer cycle (latched)
//   STEP_MODE     run exactly one computer cycle per STEP pulse
//   STEP          single-step pulse, honoured only while idle in STEP_MODE
//   PH            FANOUT identical copies per phase, [p*FANOUT +: FANOUT]
//   PHN           inverted phase, one line per phase
//   PHDA          data-advance phase; like PH but low on the last ON clock
//   PHASE_IDX     index of the current or last active phase
//   CYCLE_START   one-clock pulse on the first ON clock of phase 0
//   HALTED        sequencer idle
module phase_sequencer #(
    parameter int NPHASE     = 4,
    parameter int FANOUT     = 8,
    parameter int ON_CYCLES  = 2,
    parameter int GAP_CYCLES = 1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        BOP,
    input  logic                        HALT_REQ,
    input  logic                        STEP_MODE,
    input  logic                        STEP,
    output logic [NPHASE*FANOUT-1:0]    PH,
    output logic [NPHASE-1:0]           PHN,
    output logic [NPHASE-1:0]           PHDA,
    output logic [$clog2(NPHASE)-1:0]   PHASE_IDX,
    output logic                        CYCLE_START,
    output logic                        HALTED
);

    localparam int PW   = $clog2(NPHASE);
    localparam int MAXC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int DW   = $clog2(MAXC + 1);

    localparam logic [PW-1:0] LAST_P   = PW'(NPHASE - 1);
    localparam logic [PW-1:0] ONE_P    = PW'(1);
    localparam logic [DW-1:0] ONE_D    = DW'(1);
    localparam logic [DW-1:0] ON_LAST  = DW'(ON_CYCLES - 1);
    localparam logic [DW-1:0] GAP_LAST = DW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_GAP
    } state_t;

    state_t            state, state_nx;
    logic [PW-1:0]     p, p_nx;
    logic [DW-1:0]     d, d_nx;
    logic              halt_lat, halt_lat_nx;
    logic              parked, parked_nx;
    logic              seg_end, to_idle, start;
    logic [NPHASE-1:0] ph_nx, phda_nx, ph_q;
    logic              cs_nx, halted_nx;

    // Sequencer state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            p        <= '0;
            d        <= '0;
            halt_lat <= 1'b0;
            parked   <= 1'b0;
        end else begin
            state    <= state_nx;
            p        <= p_nx;
            d        <= d_nx;
            halt_lat <= halt_lat_nx;
            parked   <= parked_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        p_nx        = p;
        d_nx        = d;
        halt_lat_nx = halt_lat | HALT_REQ;
        // A halt parks the sequencer; dropping BOP releases the park so the
        // next power-on starts a fresh free-running cycle.
        parked_nx   = parked & BOP;
        seg_end     = 1'b0;
        to_idle     = !BOP || ((p == LAST_P) && (halt_lat || STEP_MODE));
        start       = BOP && (STEP_MODE ? STEP : (!halt_lat && !parked));

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx  = S_ON;
                    p_nx      = '0;
                    d_nx      = '0;
                    parked_nx = 1'b0;
                end
            end
            S_ON: begin
                if (d == ON_LAST) begin
                    if (GAP_CYCLES > 0) begin
                        state_nx = S_GAP;
                        d_nx     = '0;
                    end else begin
                        seg_end = 1'b1;
                    end
                end else begin
                    d_nx = d + ONE_D;
                end
            end
            S_GAP: begin
                if (d == GAP_LAST) begin
                    seg_end = 1'b1;
                end else begin
                    d_nx = d + ONE_D;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        // End of a phase slot: stop, or move on to the next phase.
        if (seg_end) begin
            d_nx = '0;
            if (to_idle) begin
                state_nx = S_IDLE;
                if (BOP && (p == LAST_P) && halt_lat) begin
                    halt_lat_nx = HALT_REQ;
                    parked_nx   = 1'b1;
                end
            end else begin
                state_nx = S_ON;
                p_nx     = (p == LAST_P) ? '0 : p + ONE_P;
            end
        end

        // Output decode from the current state; registered below.
        ph_nx   = '0;
        phda_nx = '0;
        for (int i = 0; i < NPHASE; i++) begin
            if ((state == S_ON) && (p == PW'(i))) begin
                ph_nx[i]   = 1'b1;
                phda_nx[i] = (ON_CYCLES == 1) || (d != ON_LAST);
            end
        end
        cs_nx     = (state == S_ON) && (p == '0) && (d == '0);
        halted_nx = (state == S_IDLE);
    end

    // Output register stage
    always_ff @(posedge CLK) begin
        if (RST) begin
            ph_q        <= '0;
            PHN         <= '1;
            PHDA        <= '0;
            PHASE_IDX   <= '0;
            CYCLE_START <= 1'b0;
            HALTED      <= 1'b1;
        end else begin
            ph_q        <= ph_nx;
            PHN         <= ~ph_nx;
            PHDA        <= phda_nx;
            PHASE_IDX   <= p;
            CYCLE_START <= cs_nx;
            HALTED      <= halted_nx;
        end
    end

    for (genvar g = 0; g < NPHASE; g++) begin : g_fanout
        assign PH[g*FANOUT +: FANOUT] = {FANOUT{ph_q[g]}};
    end

endmodule

// File: tb/tb_phase_sequencer.sv
module tb_phase_sequencer;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Default instance: NPHASE=4, FANOUT=8, ON=2, GAP=1
    logic        rst1, bop1, hr1, sm1, st1;
    logic [31:0] ph1;
    logic [3:0]  phn1, phda1;
    logic [1:0]  idx1;
    logic        cs1, halted1;

    // Second instance: NPHASE=6, FANOUT=3, ON=1, GAP=0
    logic        rst2, bop2, hr2, sm2, st2;
    logic [17:0] ph2;
    logic [5:0]  phn2, phda2;
    logic [2:0]  idx2;
    logic        cs2, halted2;

    phase_sequencer dut1 (
        .CLK(CLK), .RST(rst1), .BOP(bop1), .HALT_REQ(hr1), .STEP_MODE(sm1), .STEP(st1),
        .PH(ph1), .PHN(phn1), .PHDA(phda1), .PHASE_IDX(idx1), .CYCLE_START(cs1), .HALTED(halted1)
    );

    phase_sequencer #(.NPHASE(6), .FANOUT(3), .ON_CYCLES(1), .GAP_CYCLES(0)) dut2 (
        .CLK(CLK), .RST(rst2), .BOP(bop2), .HALT_REQ(hr2), .STEP_MODE(sm2), .STEP(st2),
        .PH(ph2), .PHN(phn2), .PHDA(phda2), .PHASE_IDX(idx2), .CYCLE_START(cs2), .HALTED(halted2)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // One computer cycle of the default instance, indexed by clocks since PH0 rose.
    logic [3:0] ph_t [12] = '{4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h0};
    logic [3:0] da_t [12] = '{4'h1, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0};
    logic [1:0] ix_t [12] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [5:0] ph2_t [6] = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s clock=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    function automatic logic [31:0] expand1(input logic [3:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = {8{v[i]}};
        return r;
    endfunction

    function automatic logic [3:0] fold1(input logic [31:0] v);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = v[i*8];
        return r;
    endfunction

    function automatic logic [17:0] expand2(input logic [5:0] v);
        logic [17:0] r;
        r = '0;
        for (int i = 0; i < 6; i++) r[i*3 +: 3] = {3{v[i]}};
        return r;
    endfunction

    function automatic logic [5:0] fold2(input logic [17:0] v);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) r[i] = v[i*3];
        return r;
    endfunction

    // Compare default-instance outputs with one table entry (run) or the idle state.
    task automatic exp1(input string tag, input bit run, input int off, input logic [1:0] iidx);
        logic [3:0] e, en, ed;
        logic [1:0] ei;
        logic       ec;
        if (run) begin
            e  = ph_t[off % 12];
            ed = da_t[off % 12];
            ei = ix_t[off % 12];
            ec = (off % 12) == 0;
        end else begin
            e  = 4'h0;
            ed = 4'h0;
            ei = iidx;
            ec = 1'b0;
        end
        en = ~e;
        check({tag, "_ph"},     64'(ph1),     64'(expand1(e)));
        check({tag, "_phn"},    64'(phn1),    64'(en));
        check({tag, "_phda"},   64'(phda1),   64'(ed));
        check({tag, "_idx"},    64'(idx1),    64'(ei));
        check({tag, "_cs"},     64'(cs1),     64'(ec));
        check({tag, "_halted"}, 64'(halted1), 64'(!run));
    endtask

    task automatic exp2(input string tag, input bit run, input int off, input logic [2:0] iidx);
        logic [5:0] e, en;
        logic [2:0] ei;
        logic       ec;
        if (run) begin
            e  = ph2_t[off % 6];
            ei = 3'(off % 6);
            ec = (off % 6) == 0;
        end else begin
            e  = 6'h0;
            ei = iidx;
            ec = 1'b0;
        end
        en = ~e;
        check({tag, "_ph"},     64'(ph2),     64'(expand2(e)));
        check({tag, "_phn"},    64'(phn2),    64'(en));
        check({tag, "_phda"},   64'(phda2),   64'(e));
        check({tag, "_idx"},    64'(idx2),    64'(ei));
        check({tag, "_cs"},     64'(cs2),     64'(ec));
        check({tag, "_halted"}, 64'(halted2), 64'(!run));
    endtask

    task automatic reset1(input string tag);
        rst1 = 1'b1; bop1 = 1'b0; hr1 = 1'b0; sm1 = 1'b0; st1 = 1'b0;
        tick();
        exp1(tag, 1'b0, 0, 2'd0);
        rst1 = 1'b0;
    endtask

    initial begin
        logic [3:0] f1, nf1;
        logic [5:0] f2, nf2;

        rst1 = 1'b1; bop1 = 1'b0; hr1 = 1'b0; sm1 = 1'b0; st1 = 1'b0;
        rst2 = 1'b1; bop2 = 1'b0; hr2 = 1'b0; sm2 = 1'b0; st2 = 1'b0;
        tick();
        tick();
        exp2("rst2_init", 1'b0, 0, 3'd0);

        // Free run from reset: BOP high at edge 0, PH0 at clock 1, two cycles.
        reset1("rst_free");
        bop1 = 1'b1;
        cyc  = -1;
        tick();
        exp1("latency", 1'b0, 0, 2'd0);
        for (int k = 1; k <= 25; k++) begin
            tick();
            exp1("free", 1'b1, cyc - 1, 2'd0);
        end

        // Halt pulse at clock 5: cycle completes, HALTED from 13, no restart.
        reset1("rst_halt");
        bop1 = 1'b1;
        cyc  = -1;
        tick();
        for (int k = 1; k <= 24; k++) begin
            hr1 = (k == 5);
            tick();
            exp1("halt", cyc <= 12, cyc - 1, 2'd3);
        end
        hr1 = 1'b0;

        // Single step: STEP at 20 and 40 run one cycle each; STEP at 25 ignored.
        reset1("rst_step");
        bop1 = 1'b1;
        sm1  = 1'b1;
        cyc  = -1;
        tick();
        for (int k = 1; k <= 55; k++) begin
            st1 = (k == 20) || (k == 25) || (k == 40);
            tick();
            exp1("step", ((cyc >= 21) && (cyc <= 32)) || ((cyc >= 41) && (cyc <= 52)),
                 (cyc >= 41) ? cyc - 41 : cyc - 21, (cyc < 21) ? 2'd0 : 2'd3);
        end
        st1 = 1'b0;
        sm1 = 1'b0;

        // BOP falls during phase 2: finishes ON and gap, idle at 10, restart at 16.
        reset1("rst_bop");
        bop1 = 1'b1;
        cyc  = -1;
        tick();
        for (int k = 1; k <= 20; k++) begin
            bop1 = !((k >= 8) && (k <= 14));
            tick();
            exp1("bop", (cyc <= 9) || (cyc >= 16), (cyc >= 16) ? cyc - 16 : cyc - 1, 2'd2);
        end

        // Six phases, ON=1, GAP=0: one phase per clock, then reset at phase 3.
        rst2 = 1'b0;
        bop2 = 1'b1;
        cyc  = -1;
        tick();
        exp2("n6_latency", 1'b0, 0, 3'd0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp2("n6", 1'b1, cyc - 1, 3'd0);
        end
        rst2 = 1'b1;
        tick();
        exp2("n6_rst", 1'b0, 0, 3'd0);
        rst2 = 1'b0;
        tick();
        exp2("n6_idle", 1'b0, 0, 3'd0);
        tick();
        exp2("n6_restart", 1'b1, 0, 3'd0);

        // Random inputs on both instances: structural invariants every clock.
        for (int k = 0; k < 1000; k++) begin
            bop1 = ($urandom_range(0, 15) != 0);
            hr1  = ($urandom_range(0, 31) == 0);
            st1  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 63) == 0) sm1 = ~sm1;
            bop2 = ($urandom_range(0, 15) != 0);
            hr2  = ($urandom_range(0, 31) == 0);
            st2  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 63) == 0) sm2 = ~sm2;
            tick();
            f1  = fold1(ph1);
            nf1 = ~f1;
            f2  = fold2(ph2);
            nf2 = ~f2;
            check("rnd1_onehot", 64'($countones(f1) <= 1), 64'(1));
            check("rnd1_copies", 64'(ph1), 64'(expand1(f1)));
            check("rnd1_phn",    64'(phn1), 64'(nf1));
            check("rnd1_phda",   64'(phda1 & nf1), 64'(0));
            check("rnd2_onehot", 64'($countones(f2) <= 1), 64'(1));
            check("rnd2_copies", 64'(ph2), 64'(expand2(f2)));
            check("rnd2_phn",    64'(phn2), 64'(nf2));
            check("rnd2_phda",   64'(phda2 & nf2), 64'(0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
